// File: rtl/bram_storage_pkg.sv
// Shared types and widths for the block-RAM storage stage.
package dwbmem_bram_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 4;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

// File: rtl/bram_storage_if.sv
// Flat memory-request bundle between the Wishbone front-end (master) and storage (slave).
interface bram_storage_if;
    import dwbmem_bram_pkg::*;

    logic [31:0]       addr_i;
    logic              read_i;
    logic              write_i;
    logic [DATA_W-1:0] write_data_i;
    logic [SEL_W-1:0]  sel_i;
    logic              clear_i;
    logic [DATA_W-1:0] read_data_o;
    logic              ready_o;
    logic              err_o;

    modport master (
        output addr_i, read_i, write_i, write_data_i, sel_i, clear_i,
        input  read_data_o, ready_o, err_o
    );

    modport slave (
        input  addr_i, read_i, write_i, write_data_i, sel_i, clear_i,
        output read_data_o, ready_o, err_o
    );

endinterface

// File: rtl/bram_storage_array.sv
// Inferable single-port RAM with per-byte-lane write enables and read-first registered output.
module bram_array
    import dwbmem_bram_pkg::*;
#(
    parameter int unsigned DEPTH = 4096,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic [SEL_W-1:0]  we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        for (int l = 0; l < int'(SEL_W); l++) begin
            if (we_i[l]) begin
                r_mem[addr_i][8*l +: 8] <= wdata_i[8*l +: 8];
            end
        end
        rdata_o <= r_mem[addr_i];
    end

endmodule

// File: rtl/bram_storage.sv
// Word-organised storage stage: address decode, zero-fill sequencer, error flag and read-data hold.
module bram_storage
    import dwbmem_bram_pkg::*;
#(
    parameter int unsigned DEPTH          = 4096,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    bram_storage_if.slave bus
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [32:0] SPAN     = 33'(DEPTH) * 33'd4;
    localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);

    state_t            r_state;
    logic [AW-1:0]     r_clear_cnt;
    logic              r_ready;
    logic              r_err;
    logic              r_use_array;
    logic [DATA_W-1:0] r_hold;

    logic [31:0]       w_offset;
    logic              w_in_range;
    logic [AW-1:0]     w_index;
    logic [SEL_W-1:0]  w_we;
    logic [AW-1:0]     w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata;

    always_comb begin
        w_offset   = bus.addr_i - BASE_ADDR;
        w_in_range = ({1'b0, w_offset} < SPAN);
        w_index    = w_offset[AW+1:2];
    end

    always_comb begin
        w_we    = '0;
        w_addr  = w_index;
        w_wdata = bus.write_data_i;
        if (r_state == CLEAR) begin
            w_we    = '1;
            w_addr  = r_clear_cnt;
            w_wdata = '0;
        end else if (bus.write_i && w_in_range) begin
            w_we = bus.sel_i;
        end
    end

    bram_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (w_we),
        .addr_i  (w_addr),
        .wdata_i (w_wdata),
        .rdata_o (w_rdata)
    );

    // The array output follows its address every cycle, so the last serviced read is
    // captured into r_hold one edge later to keep read_data_o stable between reads.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= CLEAR_ON_RESET ? CLEAR : READY;
            r_clear_cnt <= '0;
            r_ready     <= !CLEAR_ON_RESET;
            r_err       <= 1'b0;
            r_use_array <= 1'b0;
            r_hold      <= '0;
        end else begin
            r_err       <= 1'b0;
            r_use_array <= 1'b0;
            if (r_use_array) begin
                r_hold <= w_rdata;
            end
            unique case (r_state)
                CLEAR: begin
                    r_clear_cnt <= r_clear_cnt + 1'b1;
                    if (r_clear_cnt == LAST) begin
                        r_state <= READY;
                        r_ready <= 1'b1;
                    end
                end
                READY: begin
                    if ((bus.read_i || bus.write_i) && !w_in_range) begin
                        r_err <= 1'b1;
                    end
                    if (bus.read_i) begin
                        if (w_in_range) begin
                            r_use_array <= 1'b1;
                        end else begin
                            r_hold <= '0;
                        end
                    end
                    if (bus.clear_i) begin
                        r_state     <= CLEAR;
                        r_clear_cnt <= '0;
                        r_ready     <= 1'b0;
                    end
                end
                default: r_state <= CLEAR;
            endcase
        end
    end

    assign bus.read_data_o = r_use_array ? w_rdata : r_hold;
    assign bus.ready_o     = r_ready;
    assign bus.err_o       = r_err;

endmodule

// File: tb/tb_bram_storage.sv
// Randomised self-checking bench for bram_storage against a word-array reference model.
module tb_bram_storage;
    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bram_storage_if bus ();

    bram_storage #(
        .DEPTH          (DEPTH),
        .BASE_ADDR      (BASE),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_rd;
    logic        m_err;
    int          m_clear_left;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rd         = 32'h0;
        m_err        = 1'b0;
        m_clear_left = DEPTH;
    endtask

    // One clock of the reference: zero-fill in progress, else service the request.
    task automatic model_step(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] sel, input logic clr);
        logic [31:0] off;
        int          idx;
        m_err = 1'b0;
        if (m_clear_left > 0) begin
            m_mem[DEPTH - m_clear_left] = 32'h0;
            m_clear_left--;
        end else begin
            off = addr - BASE;
            idx = int'(off / 4);
            if (off < DEPTH * 4) begin
                if (rd) m_rd = m_mem[idx];
                if (wr) begin
                    for (int l = 0; l < 4; l++)
                        if (sel[l]) m_mem[idx][8*l +: 8] = data[8*l +: 8];
                end
            end else begin
                if (rd) m_rd = 32'h0;
                if (rd || wr) m_err = 1'b1;
            end
            if (clr) m_clear_left = DEPTH;
        end
    endtask

    task automatic step(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] sel, input logic clr);
        bus.read_i       = rd;
        bus.write_i      = wr;
        bus.addr_i       = addr;
        bus.write_data_i = data;
        bus.sel_i        = sel;
        bus.clear_i      = clr;
        @(posedge clk);
        model_step(rd, wr, addr, data, sel, clr);
        #1;
        check("ready", {31'b0, bus.ready_o}, {31'b0, (m_clear_left == 0)});
        check("err", {31'b0, bus.err_o}, {31'b0, m_err});
        check("rdata", bus.read_data_o, m_rd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, BASE, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic sweep();
        for (int i = 0; i < int'(DEPTH); i++)
            step(1'b1, 1'b0, BASE + 32'(4 * i), 32'h0, 4'h0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = $urandom;
        bus.read_i = 1'b0; bus.write_i = 1'b0; bus.addr_i = BASE;
        bus.write_data_i = 32'h0; bus.sel_i = 4'h0; bus.clear_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, bus.ready_o}, 32'h0);
        check("rst_err", {31'b0, bus.err_o}, 32'h0);
        check("rst_rdata", bus.read_data_o, 32'h0);
        rst = 1'b0;

        // Reads and writes during the initial zero-fill must be ignored.
        for (int i = 0; i < 18; i++)
            step(1'b1, 1'b1, BASE + 32'(4 * (i % DEPTH)), 32'hFFFF_FFFF, 4'hF, 1'b1);
        sweep();

        step(1'b0, 1'b1, BASE + 32'h8, 32'hDEAD_BEEF, 4'hF, 1'b0);
        step(1'b0, 1'b1, BASE + 32'h8, 32'h0000_0011, 4'b0001, 1'b0);
        step(1'b1, 1'b0, BASE + 32'h8, 32'h0, 4'h0, 1'b0);
        check("lane_merge", bus.read_data_o, 32'hDEAD_BE11);

        step(1'b0, 1'b1, BASE + 32'h4, 32'h1234_5678, 4'hF, 1'b0);
        step(1'b1, 1'b1, BASE + 32'h4, 32'hCAFE_F00D, 4'hF, 1'b0);
        check("read_first", bus.read_data_o, 32'h1234_5678);
        step(1'b1, 1'b0, BASE + 32'h4, 32'h0, 4'h0, 1'b0);
        check("after_write", bus.read_data_o, 32'hCAFE_F00D);

        step(1'b1, 1'b0, 32'h0000_1040, 32'h0, 4'h0, 1'b0);
        check("oor_hi_err", {31'b0, bus.err_o}, 32'h1);
        step(1'b1, 1'b0, 32'h0000_0FFC, 32'h0, 4'h0, 1'b0);
        check("oor_lo_rdata", bus.read_data_o, 32'h0);
        step(1'b0, 1'b1, 32'h0000_1040, 32'hA5A5_A5A5, 4'hF, 1'b0);
        idle(2);
        sweep();

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 32'($urandom_range(32'h0FE0, 32'h1060)), $urandom, 4'($urandom),
                 1'($urandom_range(0, 63) == 0));
        end
        idle(DEPTH + 2);
        sweep();

        // Clear on request, with a same-cycle read serviced first.
        for (int i = 0; i < int'(DEPTH); i++)
            step(1'b0, 1'b1, BASE + 32'(4 * i), $urandom | 32'h1, 4'hF, 1'b0);
        step(1'b1, 1'b0, BASE + 32'h8, 32'h0, 4'h0, 1'b1);
        idle(DEPTH + 2);
        sweep();

        // Async reset in the middle of a clear sequence.
        for (int i = 0; i < int'(DEPTH); i++)
            step(1'b0, 1'b1, BASE + 32'(4 * i), $urandom | 32'h1, 4'hF, 1'b0);
        step(1'b1, 1'b0, BASE + 32'hC, 32'h0, 4'h0, 1'b1);
        idle(5);
        rst = 1'b1;
        #1;
        model_reset();
        check("midclr_ready", {31'b0, bus.ready_o}, 32'h0);
        check("midclr_rdata", bus.read_data_o, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(DEPTH + 2);
        sweep();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
